ddr4_request_queue: RTL and testbench
=====================================

Name: ddr4_request_queue

Overview:
- Sits directly downstream of the trace-file parser and upstream of the DDR4 command scheduler.
- Buffers CPU memory requests (CPU clock stamp, command, 36-bit address) in a DEPTH-entry in-order FIFO.
- Decodes each address into DDR4 fields at enqueue.
- Returns full/empty back-pressure to the parser and signals end-of-trace once the parser is done and the queue has drained.

Parameters:
- DEPTH, 16, number of queue entries; power of two, at least 2.
- ADDR_W, 36, request address width.
- PTR_W, 4, log2(DEPTH).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  parser request valid.
- in_clock_number  in  64  CPU cycle stamp of the request.
- in_command  in  32  0 = data read, 1 = data write, 2 = instruction fetch.
- in_address  in  36  byte address.
- in_done  in  1  parser has finished the trace; sticky once high.
- full_out  out  1  queue full; drives the parser's full input.
- empty_out  out  1  queue empty; drives the parser's empty input.
- out_valid  out  1  head entry valid.
- out_ready  in  1  scheduler pops the head.
- out_clock_number  out  64  head entry cycle stamp.
- out_command  out  2  head entry command.
- out_row  out  16  address[35:20].
- out_col  out  10  {address[19:12], address[5:4]}.
- out_bank  out  2  address[11:10].
- out_bank_group  out  3  address[9:7].
- occupancy  out  PTR_W+1  number of valid entries, 0..DEPTH.
- drop_count  out  16  count of rejected requests.
- all_done  out  1  in_done is high and the queue is empty.

Behaviour:
- Reset (synchronous, active-high): all state clears on the next rising clock edge with reset high.
  - Pointers = 0, occupancy = 0, drop_count = 0.
  - full_out = 0, empty_out = 1, out_valid = 0, all_done = 0.
  - Head data outputs = 0.
  - Reset mid-operation discards all entries. Nothing is popped or pushed in the reset cycle.
- Push: a rising clock edge with in_valid = 1 and in_command <= 2 and occupancy < DEPTH writes the entry at the write pointer. Write pointer then increments mod DEPTH.
  - Decode happens at enqueue; only decoded fields are stored: 64-bit stamp, 2-bit command, row, col, bank, bank group. address[6] and address[3:0] are discarded.
- Drop: in_valid = 1 with in_command > 2, or with occupancy == DEPTH, discards the request.
  - drop_count increments and saturates at 16'hFFFF.
  - Pushing at full is a drop even when a pop happens in the same cycle.
- Pop: out_valid = 1 and out_ready = 1 at a rising edge advances the read pointer mod DEPTH. out_ready while empty has no effect.
- Head outputs: combinational read of the entry at the read pointer.
  - Zero latency from enqueue to visibility is not allowed: an entry pushed at edge N is first visible as out_valid = 1 after edge N (registered occupancy).
  - Head outputs are stable while out_valid = 1 and out_ready = 0.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Simultaneous push and pop with occupancy == 0: push only; the pop is ignored.
- Registered flags, derived from occupancy after each edge:
  - full_out = (occupancy == DEPTH).
  - empty_out = (occupancy == 0).
  - out_valid = !empty_out.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. Ordering is strictly FIFO across wrap.
- in_done is latched into done_seen (cleared only by reset). all_done = done_seen && empty_out, registered.
  - Requests arriving after in_done are still accepted.
- occupancy never exceeds DEPTH or underflows below 0; assertions are required in the bench.

Test Plan:
- Reset, then push one request (stamp 5, cmd 1, addr 36'hF_0012_3C80) -> next cycle out_valid = 1, out_row = 16'hF001, out_bank = 2'b11, out_bank_group = 3'b001, out_col = 10'h8C, out_command = 1, occupancy = 1, empty_out = 0.
- Push 16 requests with out_ready = 0, then a 17th -> full_out = 1 after the 16th; the 17th is dropped, drop_count = 1, occupancy = 16.
- From full, assert in_valid and out_ready in the same cycle -> the pop occurs, the push is dropped, occupancy = 15, drop_count increments.
- Push cmd = 3 -> no enqueue, drop_count = 1, empty_out stays 1.
- Push 24 and pop 24 interleaved with random out_ready -> pops return stamps 0..23 in order across pointer wrap; final occupancy = 0.
- With 3 entries queued, assert in_done, then pop all 3 -> all_done = 1 one cycle after the last pop. Assert reset with 5 entries queued -> next cycle occupancy = 0, out_valid = 0, all_done = 0.

Source files
------------

// File: rtl/ddr4_request_queue.sv
// ddr4_request_queue: in-order request FIFO between the trace parser and the
// DDR4 command scheduler. Addresses are decoded into row/col/bank/bank-group
// on enqueue so the scheduler sees ready-made fields at the head.
module ddr4_request_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 36,
  parameter int PTR_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [63:0]       in_clock_number,
  input  logic [31:0]       in_command,
  input  logic [ADDR_W-1:0] in_address,
  input  logic              in_done,
  output logic              full_out,
  output logic              empty_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_clock_number,
  output logic [1:0]        out_command,
  output logic [15:0]       out_row,
  output logic [9:0]        out_col,
  output logic [1:0]        out_bank,
  output logic [2:0]        out_bank_group,
  output logic [PTR_W:0]    occupancy,
  output logic [15:0]       drop_count,
  output logic              all_done
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Only decoded fields are stored; address[6] and address[3:0] never reach the scheduler.
  typedef struct packed {
    logic [63:0] stamp;
    logic [1:0]  cmd;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     occ_next;
  logic               done_seen;
  logic               cmd_ok;
  logic               push;
  logic               pop;
  logic               drop;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{in_address[6], in_address[3:0]};

  // A push is judged against the registered occupancy, so a full queue drops
  // even if the head is popped in the same cycle.
  assign cmd_ok = (in_command <= 32'd2);
  assign push   = in_valid && cmd_ok && (occupancy != FULL_CNT);
  assign drop   = in_valid && !push;
  assign pop    = out_valid && out_ready;

  // Address decode of the incoming request.
  always_comb begin
    new_entry.stamp = in_clock_number;
    new_entry.cmd   = in_command[1:0];
    new_entry.row   = in_address[35:20];
    new_entry.col   = {in_address[19:12], in_address[5:4]};
    new_entry.bank  = in_address[11:10];
    new_entry.bg    = in_address[9:7];
  end

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    occ_next = occupancy;
    if (push && !pop)      occ_next = occupancy + (PTR_W+1)'(1);
    else if (pop && !push) occ_next = occupancy - (PTR_W+1)'(1);
  end

  // Pointers, occupancy, registered flags, drop counter and end-of-trace tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      drop_count <= '0;
      full_out   <= 1'b0;
      empty_out  <= 1'b1;
      out_valid  <= 1'b0;
      done_seen  <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occ_next;
      full_out  <= (occ_next == FULL_CNT);
      empty_out <= (occ_next == '0);
      out_valid <= (occ_next != '0);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      done_seen <= done_seen | in_done;
      all_done  <= done_seen && empty_out;
    end
  end

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= new_entry;
  end

  // Combinational head read, forced to zero while the queue is empty.
  always_comb begin
    head             = out_valid ? mem[rd_ptr] : '0;
    out_clock_number = head.stamp;
    out_command      = head.cmd;
    out_row          = head.row;
    out_col          = head.col;
    out_bank         = head.bank;
    out_bank_group   = head.bg;
  end

endmodule

// File: tb/tb_ddr4_request_queue.sv
// Bench for ddr4_request_queue: directed vector table, hand sequences for
// full/done/reset corners, and random traffic against a queue-based model.
module tb_ddr4_request_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_clock_number = '0;
  logic [31:0] in_command = '0;
  logic [35:0] in_address = '0;
  logic        in_done = 1'b0;
  logic        full_out, empty_out, out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_clock_number;
  logic [1:0]  out_command;
  logic [15:0] out_row;
  logic [9:0]  out_col;
  logic [1:0]  out_bank;
  logic [2:0]  out_bank_group;
  logic [4:0]  occupancy;
  logic [15:0] drop_count;
  logic        all_done;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  ddr4_request_queue #(.DEPTH(16), .ADDR_W(36), .PTR_W(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_clock_number(in_clock_number), .in_command(in_command),
    .in_address(in_address), .in_done(in_done), .full_out(full_out),
    .empty_out(empty_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_clock_number(out_clock_number), .out_command(out_command),
    .out_row(out_row), .out_col(out_col), .out_bank(out_bank),
    .out_bank_group(out_bank_group), .occupancy(occupancy),
    .drop_count(drop_count), .all_done(all_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (started && !reset)
      assert (occupancy <= 5'd16)
      else begin
        bad++;
        $display("FAIL occ_bound: got %0d want <=16", occupancy);
      end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [35:0] a,
                       input logic [63:0] s, input logic r);
    in_valid = v; in_command = c; in_address = a; in_clock_number = s; out_ready = r;
  endtask

  task automatic chk_head(input string t, input logic [63:0] s, input logic [1:0] c,
                          input logic [15:0] row, input logic [9:0] col,
                          input logic [1:0] bk, input logic [2:0] bg);
    chk({t, "_stamp"}, out_clock_number, s);
    chk({t, "_cmd"},   64'(out_command), 64'(c));
    chk({t, "_row"},   64'(out_row), 64'(row));
    chk({t, "_col"},   64'(out_col), 64'(col));
    chk({t, "_bank"},  64'(out_bank), 64'(bk));
    chk({t, "_bg"},    64'(out_bank_group), 64'(bg));
  endtask

  // ---------------- reference model ----------------
  logic [63:0] q_stamp[$];
  logic [1:0]  q_cmd[$];
  logic [35:0] q_addr[$];
  int          m_drop;

  task automatic model_reset;
    q_stamp.delete(); q_cmd.delete(); q_addr.delete(); m_drop = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_done = 1'b0;
    drive(0, 0, 0, 0, 0);
    step;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle of traffic, with every visible output checked against the model.
  task automatic mcycle(input logic v, input logic [31:0] c, input logic [35:0] a,
                        input logic [63:0] s, input logic r);
    int sz;
    bit pu, po;
    logic [35:0] h;
    drive(v, c, a, s, r);
    sz = q_stamp.size();
    pu = v && (c <= 2) && (sz < 16);
    po = (sz > 0) && r;
    if (v && !pu && m_drop < 65535) m_drop++;
    if (po) begin void'(q_stamp.pop_front()); void'(q_cmd.pop_front()); void'(q_addr.pop_front()); end
    if (pu) begin q_stamp.push_back(s); q_cmd.push_back(c[1:0]); q_addr.push_back(a); end
    step;
    sz = q_stamp.size();
    chk("m_occ",   64'(occupancy), 64'(sz));
    chk("m_drop",  64'(drop_count), 64'(m_drop));
    chk("m_full",  64'(full_out), 64'(sz == 16));
    chk("m_empty", 64'(empty_out), 64'(sz == 0));
    chk("m_valid", 64'(out_valid), 64'(sz != 0));
    if (sz > 0) begin
      h = q_addr[0];
      chk_head("m_head", q_stamp[0], q_cmd[0], 16'(h / (36'd1 << 20)),
               10'(((h / (36'd1 << 12)) % 256) * 4 + ((h / 16) % 4)),
               2'((h / 1024) % 4), 3'((h / 128) % 8));
    end else
      chk_head("m_head", 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] cmd;
    logic [35:0] addr;
    logic [63:0] stamp;
    logic        rdy;
    int          e_occ;
    int          e_drop;
    logic        e_valid;
    logic [63:0] e_stamp;
    logic [1:0]  e_cmd;
    logic [15:0] e_row;
    logic [9:0]  e_col;
    logic [1:0]  e_bank;
    logic [2:0]  e_bg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pushed, popped, cyc;

    vecs[0] = '{1, 3, 36'h0,           9, 0, 0, 1, 0, 0, 0, 16'h0,    10'h0,   0, 0};
    vecs[1] = '{1, 1, 36'hF_0012_3C80, 5, 0, 1, 1, 1, 5, 1, 16'hF001, 10'h08C, 3, 1};
    vecs[2] = '{1, 7, 36'h0,           9, 0, 1, 2, 1, 5, 1, 16'hF001, 10'h08C, 3, 1};
    vecs[3] = '{0, 0, 36'h0,           0, 1, 0, 2, 0, 0, 0, 16'h0,    10'h0,   0, 0};
    vecs[4] = '{1, 2, 36'h0_0000_0071, 7, 1, 1, 2, 1, 7, 2, 16'h0,    10'h003, 0, 0};
    vecs[5] = '{1, 0, 36'hA_BCDE_F3B0, 8, 1, 1, 2, 1, 8, 0, 16'hABCD, 10'h3BF, 0, 7};
    vecs[6] = '{0, 0, 36'h0,           0, 1, 0, 2, 0, 0, 0, 16'h0,    10'h0,   0, 0};

    // Reset state
    step;
    do_reset();
    started = 1;
    chk("rst_occ",   64'(occupancy), 0);
    chk("rst_drop",  64'(drop_count), 0);
    chk("rst_full",  64'(full_out), 0);
    chk("rst_empty", 64'(empty_out), 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_done",  64'(all_done), 0);
    chk_head("rst_head", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].cmd, vecs[i].addr, vecs[i].stamp, vecs[i].rdy);
      step;
      chk($sformatf("v%0d_occ", i),   64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("v%0d_drop", i),  64'(drop_count), 64'(vecs[i].e_drop));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_empty", i), 64'(empty_out), 64'(vecs[i].e_occ == 0));
      chk($sformatf("v%0d_full", i),  64'(full_out), 0);
      chk_head($sformatf("v%0d", i), vecs[i].e_stamp, vecs[i].e_cmd, vecs[i].e_row,
               vecs[i].e_col, vecs[i].e_bank, vecs[i].e_bg);
    end

    // Fill to full, overflow, then push+pop at full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 36'(i * 16), 64'(100 + i), 0);
      step;
      if (i == 14) chk("fill_full15", 64'(full_out), 0);
    end
    chk("fill_full16", 64'(full_out), 1);
    chk("fill_occ16",  64'(occupancy), 16);
    drive(1, 1, 0, 200, 0);
    step;
    chk("ovf_drop", 64'(drop_count), 1);
    chk("ovf_occ",  64'(occupancy), 16);
    chk("ovf_head", out_clock_number, 100);
    drive(1, 1, 0, 201, 1);
    step;
    chk("fpp_occ",  64'(occupancy), 15);
    chk("fpp_drop", 64'(drop_count), 2);
    chk("fpp_full", 64'(full_out), 0);
    chk("fpp_head", out_clock_number, 101);

    // End-of-trace after draining
    do_reset();
    for (int i = 1; i <= 3; i++) begin drive(1, 0, 0, 64'(i), 0); step; end
    drive(0, 0, 0, 0, 0);
    in_done = 1'b1;
    step;
    chk("done_busy", 64'(all_done), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 1);
      chk($sformatf("done_pop%0d", i), out_clock_number, 64'(i));
      step;
    end
    drive(0, 0, 0, 0, 0);
    chk("done_empty", 64'(empty_out), 1);
    chk("done_lag",   64'(all_done), 0);
    step;
    chk("done_set",   64'(all_done), 1);
    // Requests after done are still accepted
    for (int i = 0; i < 5; i++) begin drive(1, 2, 0, 64'(50 + i), 0); step; end
    drive(0, 0, 0, 0, 0);
    chk("late_occ",  64'(occupancy), 5);
    chk("late_done", 64'(all_done), 0);
    // Reset with entries queued
    reset = 1'b1; in_done = 1'b0;
    step;
    reset = 1'b0;
    chk("mrst_occ",   64'(occupancy), 0);
    chk("mrst_valid", 64'(out_valid), 0);
    chk("mrst_done",  64'(all_done), 0);
    chk("mrst_empty", 64'(empty_out), 1);
    chk("mrst_stamp", out_clock_number, 0);
    model_reset();

    // 24 in-order requests across pointer wrap with random back-pressure
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 24 || popped < 24) && cyc < 2000) begin
      logic v, r;
      v = (pushed < 24) && (q_stamp.size() < 16) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      if (out_valid && r) begin
        chk("wrap_order", out_clock_number, 64'(popped));
        popped++;
      end
      mcycle(v, 32'($urandom_range(0, 2)), {$urandom, $urandom}, 64'(pushed), r);
      if (v) pushed++;
      cyc++;
    end
    chk("wrap_budget", 64'(popped), 24);
    chk("wrap_final_occ", 64'(occupancy), 0);

    // Random traffic including bad commands and overflow pressure
    for (int i = 0; i < 400; i++)
      mcycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 3)), {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 2) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
